// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed number of wait states per access.
// Optional build macro DMEM_RANGE_CHECK_EN: addresses at or beyond the end of the array fault instead of wrapping.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  // state | meaning
  // IDLE  | ready for a request (once out of reset)
  // WAIT  | request captured, counting down wait states
  // RESP  | response presented, holding until rsp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            r_rst_done;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic            r_oor;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_enter_resp;
  logic            w_req_oor;
  logic            w_we_eff;
  logic [AW-1:0]   w_idx_eff;
  logic [31:0]     w_wdata_eff;
  logic [3:0]      w_be_eff;
  logic            w_oor_eff;
  logic            w_unused_addr;

`ifdef DMEM_RANGE_CHECK_EN
  assign w_req_oor = |req_addr[31:AW+2];
`else
  assign w_req_oor = 1'b0;
`endif
  assign w_unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

  assign req_ready = (r_state == IDLE) && r_rst_done;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_accept  = req_valid && req_ready;

  // With zero wait states RESP is entered on the accept edge itself, so use the live request.
  assign w_we_eff    = (r_state == IDLE) ? req_we              : r_we;
  assign w_idx_eff   = (r_state == IDLE) ? req_addr[AW+1:2]    : r_idx;
  assign w_wdata_eff = (r_state == IDLE) ? req_wdata           : r_wdata;
  assign w_be_eff    = (r_state == IDLE) ? req_be              : r_be;
  assign w_oor_eff   = (r_state == IDLE) ? w_req_oor           : r_oor;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_rst_done <= 1'b0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_be       <= 4'd0;
      r_oor      <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_we    <= req_we;
        r_idx   <= req_addr[AW+1:2];
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_oor   <= w_req_oor;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_we_eff || w_oor_eff) ? 32'd0 : r_mem[w_idx_eff];
        r_err   <= w_oor_eff;
      end
    end
  end

  // Memory is deliberately left out of reset; a reset in WAIT never reaches RESP so nothing commits.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_we_eff && !w_oor_eff) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be_eff[i]) r_mem[w_idx_eff][8*i +: 8] <= w_wdata_eff[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance under random traffic
// and a WAIT_CYCLES=0 instance checking back-to-back accept spacing.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_be = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic        b_rsp_ready = 1'b1;
  logic [31:0] b_rsp_rdata;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [31:0] bq[$];
  logic [31:0] mem_m [DEPTH];
  int          hold_tok = 0;
  int          hold_used = 0;
  int          hold_cnt = 0;
  bit          in_resp = 0;
  bit          drop_pending = 0;
  exp_t        cur;
  int          b_prev = -1;
  int          b_acc_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: word-addressed array, byte-lane merge, read returns pre-write contents.
  function automatic exp_t model_access(input bit we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int   idx;
    bit   oor;
    idx = int'((addr >> 2) % DEPTH);
`ifdef DMEM_RANGE_CHECK_EN
    oor = (addr >= 32'(4 * DEPTH));
`else
    oor = 1'b0;
`endif
    e.err   = oor;
    e.rdata = (we || oor) ? 32'd0 : mem_m[idx];
    e.acc   = 0;
    if (we && !oor)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_m[idx][8*i +: 8] = wdata[8*i +: 8];
    return e;
  endfunction

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit track);
    int   n = 0;
    exp_t e;
    @(posedge clk); #2;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk);
    while (!req_ready && n < 100) begin n++; @(negedge clk); end
    if (!req_ready) begin
      check("req_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      e = model_access(we, addr, wdata, be);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #2;
    if (track) begin
      // Junk request while busy: must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_addr = {$urandom_range(0, 31), 2'b00};
      req_wdata = $urandom; req_be = 4'hf;
      @(posedge clk); #2;
    end
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || in_resp || drop_pending) && n < 300) begin n++; @(negedge clk); end
    if (q.size() != 0 || in_resp) check("drain_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 0;
      drop_pending = 0;
    end else begin
      if (drop_pending) begin
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(req_ready), 32'd1);
        drop_pending = 0;
      end else if (rsp_valid) begin
        if (!in_resp) begin
          if (q.size() == 0) begin
            check("spurious_rsp", 32'd1, 32'd0);
          end else begin
            cur = q.pop_front();
            in_resp = 1;
            check("latency", 32'(cyc - cur.acc), 32'(W));
            if (hold_tok != hold_used) begin hold_cnt = 5; hold_used = hold_tok; end
          end
        end
        if (in_resp) begin
          check("rsp_rdata", rsp_rdata, cur.rdata);
          check("rsp_err", 32'(rsp_err), 32'(cur.err));
          check("req_ready_busy", 32'(req_ready), 32'd0);
        end
      end
      if (hold_cnt > 0) begin
        rsp_ready = 1'b0;
        hold_cnt--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (rsp_valid && rsp_ready && in_resp) begin
        in_resp = 0;
        drop_pending = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_rsp_valid) begin
        if (bq.size() == 0) check("b_spurious_rsp", 32'd1, 32'd0);
        else begin
          check("b_rdata", b_rsp_rdata, bq.pop_front());
          check("b_err", 32'(b_rsp_err), 32'd0);
        end
      end
      if (b_req_valid && b_req_ready) begin
        if (b_prev >= 0) check("b_gap", 32'(cyc + 1 - b_prev), 32'd2);
        b_prev = cyc + 1;
        b_acc_n++;
        bq.push_back(b_req_we ? 32'd0 : 32'h1234_5678);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          n;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_pre_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_post_edge", 32'(req_ready), 32'd1);

    for (int i = 0; i < 32; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hf, 1'b1);

    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hf, 1'b1);
    do_req(1'b0, 32'h10, 32'd0,         4'hf, 1'b1);
    do_req(1'b1, 32'h10, 32'h0000_00AA, 4'h1, 1'b1);
    do_req(1'b0, 32'h10, 32'd0,         4'hf, 1'b1);
    do_req(1'b1, 32'h10, 32'h5555_5555, 4'h0, 1'b1);
    do_req(1'b0, 32'h10, 32'd0,         4'hf, 1'b1);
    drain();
    hold_tok++;
    do_req(1'b0, 32'h10, 32'd0, 4'hf, 1'b1);
    do_req(1'b0, 32'h400, 32'd0, 4'hf, 1'b1);

    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h400 * 32'($urandom_range(1, 4));
      do_req(1'($urandom), a, $urandom, 4'($urandom), 1'b1);
    end
    drain();

    do_req(1'b1, 32'h20, 32'hCAFE_0020, 4'hf, 1'b1);
    drain();
    do_req(1'b1, 32'h20, 32'h0BAD_F00D, 4'hf, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check("abort_ready_after", 32'(req_ready), 32'd1);
    check("abort_rsp_idle", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 32'h20, 32'd0, 4'hf, 1'b1);
    drain();

    @(posedge clk); #2;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h8;
    b_req_wdata = 32'h1234_5678; b_req_be = 4'hf;
    n = 0;
    @(negedge clk);
    while (!b_req_ready && n < 50) begin n++; @(negedge clk); end
    @(posedge clk); #2 b_req_we = 1'b0;
    repeat (12) @(posedge clk);
    #2 b_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b_accepts_min", 32'(b_acc_n >= 7), 32'd1);
    check("b_queue_empty", 32'(bq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
